// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   md_op_e          - MD_OP encodings, shared with the decoder stages
//   MD_MULT_CYCLES_DEF / MD_DIV_CYCLES_DEF - default busy latencies
//   md_is_arith()    - true for the ops that occupy the unit (mult..divu)
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    function automatic logic md_is_arith(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E/D-stage signal bundle between the pipeline and md_ctrl.
//   A, B       - forwarded rs/rt operands
//   MD_OP      - E-stage op, MD_CANCEL flushes it, MD_USE_D flags an MD op in D
//   MD_START, MD_BUSY, MD_STALL - unit status back to the pipeline
//   MD_OUT     - mfhi/mflo read data, HI/LO - architectural registers
// master: pipeline side, slave: md_ctrl side.
interface md_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MD_OP;
    logic        MD_CANCEL;
    logic        MD_USE_D;
    logic        MD_START;
    logic        MD_BUSY;
    logic        MD_STALL;
    logic [31:0] MD_OUT;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output A, B, MD_OP, MD_CANCEL, MD_USE_D,
        input  MD_START, MD_BUSY, MD_STALL, MD_OUT, HI, LO
    );

    modport slave (
        input  A, B, MD_OP, MD_CANCEL, MD_USE_D,
        output MD_START, MD_BUSY, MD_STALL, MD_OUT, HI, LO
    );

endinterface

// File: rtl/md_arith.sv
// md_arith: combinational 32x32 multiply / divide datapath.
//   i_a, i_b        - operands
//   i_op            - selects mult, multu, div or divu (others give zero)
//   o_hi, o_lo      - product halves, or remainder/quotient for divides
//   o_div_by_zero   - divide op with i_b == 0
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  md_op_e      i_op,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_by_zero
);

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_b_nz;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_q_s;
    logic [31:0]        w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Substitute 1 for a zero divisor; the result is discarded at commit anyway.
    assign w_b_nz = (i_b == '0) ? 32'd1 : i_b;

    // Signed divide on magnitudes: 0x80000000 / -1 then yields 0x80000000
    // with no overflow special case.
    assign w_abs_a = i_a[31]    ? (~i_a + 32'd1)    : i_a;
    assign w_abs_b = w_b_nz[31] ? (~w_b_nz + 32'd1) : w_b_nz;
    assign w_q_mag = w_abs_a / w_abs_b;
    assign w_r_mag = w_abs_a % w_abs_b;
    assign w_q_s   = (i_a[31] ^ w_b_nz[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s   = i_a[31] ? (~w_r_mag + 32'd1) : w_r_mag;

    assign w_q_u = i_a / w_b_nz;
    assign w_r_u = i_a % w_b_nz;

    always_comb begin
        o_hi          = '0;
        o_lo          = '0;
        o_div_by_zero = 1'b0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV: begin
                o_hi          = w_r_s;
                o_lo          = w_q_s;
                o_div_by_zero = (i_b == '0);
            end
            MD_DIVU: begin
                o_hi          = w_r_u;
                o_lo          = w_q_u;
                o_div_by_zero = (i_b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller beside the E-stage ALU.
//   clk, reset - core clock, synchronous active-high reset
//   bus        - md_if slave: operands/op/cancel/use_d in, start/busy/stall,
//                MD_OUT and HI/LO out
// The result is computed on the start cycle, held in pending registers for
// the busy latency, then committed to HI/LO (skipped on divide by zero).
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    md_op_e      w_op;
    logic        w_start;
    logic        w_mt_ok;
    logic        w_is_mult;
    logic [31:0] w_ar_hi;
    logic [31:0] w_ar_lo;
    logic        w_ar_dz;

    logic        r_busy;
    logic [31:0] r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_md_out;

    assign w_op      = md_op_e'(bus.MD_OP);
    assign w_start   = md_is_arith(w_op) & ~r_busy & ~bus.MD_CANCEL;
    assign w_mt_ok   = ~r_busy & ~bus.MD_CANCEL;
    assign w_is_mult = (w_op == MD_MULT) || (w_op == MD_MULTU);

    md_arith u_arith (
        .i_a           (bus.A),
        .i_b           (bus.B),
        .i_op          (w_op),
        .o_hi          (w_ar_hi),
        .o_lo          (w_ar_lo),
        .o_div_by_zero (w_ar_dz)
    );

    // Start and commit are mutually exclusive (start needs ~busy, commit needs
    // busy), and mthi/mtlo need ~busy, so HI/LO have one writer per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_start) begin
                r_pend_hi <= w_ar_hi;
                r_pend_lo <= w_ar_lo;
                r_pend_dz <= w_ar_dz;
                r_cnt     <= w_is_mult ? (MULT_CYCLES - 1) : (DIV_CYCLES - 1);
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    if (!r_pend_dz) begin
                        r_hi <= r_pend_hi;
                        r_lo <= r_pend_lo;
                    end
                end else begin
                    r_cnt <= r_cnt - 32'd1;
                end
            end
            if (w_mt_ok && (w_op == MD_MTHI)) r_hi <= bus.A;
            if (w_mt_ok && (w_op == MD_MTLO)) r_lo <= bus.A;
        end
    end

    always_comb begin
        r_md_out = '0;
        case (w_op)
            MD_MFHI: r_md_out = r_hi;
            MD_MFLO: r_md_out = r_lo;
            default: ;
        endcase
    end

    assign bus.MD_START = w_start;
    assign bus.MD_BUSY  = r_busy;
    assign bus.MD_STALL = bus.MD_USE_D & (w_start | r_busy);
    assign bus.MD_OUT   = r_md_out;
    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: table vectors, hand sequences and random traffic for md_ctrl,
// every cycle compared against a timestamp-based reference model.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md_if bus ();

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    logic [31:0] m_hi = '0, m_lo = '0, m_phi, m_plo;
    logic        m_dz, m_active = 1'b0;
    int          m_t, m_n;

    // last sampled DUT outputs
    logic        s_start, s_busy, s_stall;
    logic [31:0] s_out, s_hi, s_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int unsigned n;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, b,
                                   output logic [31:0] hi, lo, output logic dz);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0; lo = '0; dz = 1'b0;
        case (op)
            4'd1: begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
            4'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            4'd3: if (b == 0) dz = 1'b1;
                  else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            4'd4: if (b == 0) dz = 1'b1;
                  else begin p = ua / ub; lo = p[31:0]; p = ua % ub; hi = p[31:0]; end
            default: ;
        endcase
    endfunction

    // One clock cycle: drive, compare at negedge, advance model at posedge.
    task automatic cycle(input logic [3:0] op, input logic [31:0] a, b,
                         input logic cancel, use_d, r);
        logic        e_busy, e_start;
        logic [31:0] e_out;
        rst = r;
        bus.MD_OP = op; bus.A = a; bus.B = b;
        bus.MD_CANCEL = cancel; bus.MD_USE_D = use_d;
        @(negedge clk);
        e_busy  = m_active && (cyc > m_t) && (cyc <= m_t + m_n);
        e_start = (op >= 4'd1) && (op <= 4'd4) && !e_busy && !cancel;
        e_out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        s_start = bus.MD_START; s_busy = bus.MD_BUSY; s_stall = bus.MD_STALL;
        s_out = bus.MD_OUT; s_hi = bus.HI; s_lo = bus.LO;
        check("start", {31'd0, s_start}, {31'd0, e_start});
        check("busy",  {31'd0, s_busy},  {31'd0, e_busy});
        check("stall", {31'd0, s_stall}, {31'd0, use_d & (e_start | e_busy)});
        check("md_out", s_out, e_out);
        check("hi", s_hi, m_hi);
        check("lo", s_lo, m_lo);
        @(posedge clk);
        if (r) begin
            m_hi = '0; m_lo = '0; m_active = 1'b0;
        end else begin
            if (m_active && cyc == m_t + m_n) begin
                m_active = 1'b0;
                if (!m_dz) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (e_start) begin
                ref_op(op, a, b, m_phi, m_plo, m_dz);
                m_active = 1'b1;
                m_t = cyc;
                m_n = (op <= 4'd2) ? MC : DC;
            end
            if (!e_busy && !cancel && op == 4'd5) m_hi = a;
            if (!e_busy && !cancel && op == 4'd6) m_lo = a;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input logic use_d);
        cycle(4'd0, 32'd0, 32'd0, 1'b0, use_d, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        tbl[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        tbl[1] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        DC};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
        tbl[4] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        tbl[5] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        tbl[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC};

        bus.MD_OP = '0; bus.A = '0; bus.B = '0; bus.MD_CANCEL = 1'b0; bus.MD_USE_D = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        idle(1'b0);
        check("rst_busy", {31'd0, s_busy}, 32'd0);
        check("rst_hi", s_hi, 32'd0);

        // table vectors
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b1, 1'b0);
            check("tbl_start", {31'd0, s_start}, 32'd1);
            busy_cnt = 0;
            for (int k = 0; k < 14; k++) begin
                idle(1'b0);
                if (s_busy) busy_cnt++;
            end
            check("tbl_busy_len", busy_cnt, tbl[i].n);
            check("tbl_hi", s_hi, tbl[i].hi);
            check("tbl_lo", s_lo, tbl[i].lo);
        end

        // mthi, then divide by zero with a stalled MD op in D
        cycle(4'd5, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd3, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0);
        check("dz_stall_start", {31'd0, s_stall}, 32'd1);
        for (int k = 0; k < DC; k++) begin
            idle(1'b1);
            check("dz_stall_busy", {31'd0, s_stall}, 32'd1);
        end
        idle(1'b1);
        check("dz_stall_free", {31'd0, s_stall}, 32'd0);
        check("dz_hi_kept", s_hi, 32'h1234);
        cycle(4'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("mfhi", s_out, 32'h1234);

        // reset on the third busy cycle of a mult
        cycle(4'd1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cycle(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_busy_seen", {31'd0, s_busy}, 32'd1);
        idle(1'b0);
        check("mid_rst_busy", {31'd0, s_busy}, 32'd0);
        check("mid_rst_hi", s_hi, 32'd0);
        for (int k = 0; k < 8; k++) idle(1'b0);
        check("mid_rst_no_commit", s_lo, 32'd0);

        // cancelled mult
        cycle(4'd1, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0);
        check("cancel_start", {31'd0, s_start}, 32'd0);
        idle(1'b0);
        check("cancel_busy", {31'd0, s_busy}, 32'd0);

        // random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            cycle(op, a, b, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
